// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, reset default and fetch FSM state type for the MIPS core.
//   INSTR_W          instruction word width
//   ADDR_W           byte address width
//   RESET_PC_DEFAULT default PC of the first fetch after reset
//   fetch_state_e    fetch FSM states: boot cycle, normal run, flushing squashed responses
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry in-order ring of {pc, data, filled} entries.
// An entry is allocated with its PC when a request is accepted, filled by the oldest outstanding
// response, and popped from the head once filled.
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   alloc, alloc_pc       allocate tail entry with its PC
//   fill, fill_data       fill the oldest unfilled entry
//   pop                   retire the head entry
//   flush                 discard every entry
//   head_valid/pc/data    head entry, valid once filled
//   used                  allocated entries (filled or not)
//   unfilled              allocated entries still waiting for their response
module fetch_buffer
    import mips_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alloc,
    input  logic [ADDR_W-1:0]  alloc_pc,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_data,
    input  logic               pop,
    input  logic               flush,
    output logic               head_valid,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_data,
    output logic [CNT_W-1:0]   used,
    output logic [CNT_W-1:0]   unfilled
);

    // Pointers carry one extra wrap bit so differences give occupancy directly.
    logic [CNT_W-1:0]   head_q, fill_q, tail_q;
    logic [ADDR_W-1:0]  pc_q   [DEPTH];
    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]   filled_q;

    logic [PTR_W-1:0] head_idx, fill_idx, tail_idx;

    assign head_idx = head_q[PTR_W-1:0];
    assign fill_idx = fill_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];

    assign used     = tail_q - head_q;
    assign unfilled = tail_q - fill_q;

    assign head_valid = filled_q[head_idx];
    assign head_pc    = pc_q[head_idx];
    assign head_data  = data_q[head_idx];

    // Alloc, fill and pop always touch distinct entries: alloc needs a free slot, fill needs an
    // unfilled one and pop needs a filled one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            filled_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            filled_q <= '0;
        end else begin
            if (alloc) begin
                pc_q[tail_idx]     <= alloc_pc;
                filled_q[tail_idx] <= 1'b0;
                tail_q             <= tail_q + CNT_W'(1);
            end
            if (fill) begin
                data_q[fill_idx]   <= fill_data;
                filled_q[fill_idx] <= 1'b1;
                fill_q             <= fill_q + CNT_W'(1);
            end
            if (pop) begin
                filled_q[head_idx] <= 1'b0;
                head_q             <= head_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues word reads to instruction memory,
// queues returned instructions in order and hands them to decode over valid/ready. Execute may
// redirect the PC; instructions fetched down the old path are squashed and their still-outstanding
// responses are dropped as they return.
//   clock, reset                     rising-edge clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        word read request to instruction memory
//   imem_rsp_valid/data              in-order read response, never back-pressured
//   redirect_valid/pc                taken branch/jump; low two PC bits ignored
//   inst_valid/ready/data/pc         instruction handed to decode
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic             redirect_en;
    logic             req_fire;
    logic             rsp_fill;
    logic             inst_pop;
    logic [CNT_W-1:0] used, unfilled;

    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign redirect_en = redirect_valid && (state_q != S_BOOT);

    assign imem_req_valid = (state_q == S_RUN) && (used < CNT_W'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response only fills when no squashed responses are ahead of it and the path it belongs
    // to is not being redirected away this cycle.
    assign rsp_fill = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_en;
    assign inst_pop = inst_valid && inst_ready;

    // On redirect every outstanding request becomes a drop; a response in the same cycle is
    // already one of them, so it is subtracted immediately.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_en) begin
            drop_cnt_d = drop_cnt_q + unfilled - CNT_W'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (redirect_en) begin
                pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (req_fire) begin
                pc_q <= pc_q + 32'd4;
            end
            unique case (state_q)
                S_BOOT:  state_q <= S_RUN;
                S_RUN:   if (redirect_en && (drop_cnt_d != '0)) state_q <= S_FLUSH;
                S_FLUSH: if (drop_cnt_d == '0) state_q <= S_RUN;
                default: state_q <= S_BOOT;
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock      (clock),
        .reset      (reset),
        .alloc      (req_fire),
        .alloc_pc   (pc_q),
        .fill       (rsp_fill),
        .fill_data  (imem_rsp_data),
        .pop        (inst_pop),
        .flush      (redirect_en),
        .head_valid (inst_valid),
        .head_pc    (inst_pc),
        .head_data  (inst_data),
        .used       (used),
        .unfilled   (unfilled)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a transaction-level model of the fetch
// stream (expected PC sequence, in-order instruction queue, in-order memory with random latency).
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clock = ~clock;

    // Model: instructions the fetch stage owns (in flight or buffered), oldest first.
    typedef struct {
        logic [31:0] pc;
        bit          filled;
        logic [31:0] data;
    } ent_t;

    // Memory: accepted reads awaiting their response, in order.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          squashed;
    } mreq_t;

    ent_t        bq[$];
    mreq_t       mq[$];
    logic [31:0] mpc;
    bit          booted;
    int          cyc;
    int          last_due;
    int          delivered;
    int          checks;
    int          failures;

    // Knobs for the current phase.
    int p_iready;
    int p_mready;
    int p_redir;
    int lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Enter at a falling edge; leaves reset asserted-then-released, ending at a falling edge.
    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        bq.delete();
        mq.delete();
        mpc       = RESET_PC;
        booted    = 1'b0;
        last_due  = cyc;
        #1;
        check("rst_req_valid",  {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr",   imem_req_addr, RESET_PC);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_data",  inst_data, 32'd0);
        check("rst_inst_pc",    inst_pc, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check, update the model, cross the rising edge.
    task automatic step();
        bit          rdir;
        bit          rsp;
        bit          exp_req;
        bit          exp_iv;
        bit          squash_pending;
        int          lat;
        int          due;
        logic [31:0] rpc;
        ent_t        e;
        mreq_t       m;

        rdir = booted && ($urandom_range(99, 0) < p_redir);
        rpc  = $urandom & 32'h0000_0FFF;
        rsp  = (mq.size() > 0) && (mq[0].due <= cyc);

        redirect_valid = rdir;
        redirect_pc    = rpc;
        inst_ready     = ($urandom_range(99, 0) < p_iready);
        imem_req_ready = ($urandom_range(99, 0) < p_mready);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
        #1;

        squash_pending = 1'b0;
        foreach (mq[i]) if (mq[i].squashed) squash_pending = 1'b1;
        exp_req = booted && !squash_pending && (bq.size() < DEPTH) && !rdir;
        exp_iv  = (bq.size() > 0) && bq[0].filled;

        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
        if (exp_req) check("req_addr", imem_req_addr, mpc);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});
        if (exp_iv) begin
            check("inst_pc", inst_pc, bq[0].pc);
            check("inst_data", inst_data, bq[0].data);
        end

        if (exp_iv && inst_ready) begin
            void'(bq.pop_front());
            delivered++;
        end
        if (rdir) begin
            foreach (mq[i]) mq[i].squashed = 1'b1;
            bq.delete();
            mpc = rpc & ~32'd3;
        end
        if (rsp) begin
            m = mq.pop_front();
            if (!m.squashed) begin
                for (int i = 0; i < bq.size(); i++) begin
                    if (!bq[i].filled) begin
                        bq[i].filled = 1'b1;
                        bq[i].data   = mem_word(m.addr);
                        break;
                    end
                end
            end
        end
        if (exp_req && imem_req_ready) begin
            e.pc     = mpc;
            e.filled = 1'b0;
            e.data   = '0;
            bq.push_back(e);
            lat = $urandom_range(lat_max, 1);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            m.addr     = mpc;
            m.due      = due;
            m.squashed = 1'b0;
            mq.push_back(m);
            last_due = due;
            mpc      = mpc + 32'd4;
        end

        @(posedge clock);
        cyc++;
        booted = 1'b1;
        @(negedge clock);
    endtask

    task automatic run_phase(input int n, input int pi, input int pm, input int pr, input int lm);
        p_iready = pi;
        p_mready = pm;
        p_redir  = pr;
        lat_max  = lm;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        delivered = 0;
        reset     = 1'b1;
        @(negedge clock);
        do_reset();

        // Streaming with an always-ready memory and decoder.
        run_phase(40, 100, 100, 0, 1);
        check("stream_progress", {31'd0, delivered >= 20}, 32'd1);

        // Decoder stalls so the buffer fills and requests stop; then resumes.
        run_phase(12, 0, 100, 0, 1);
        run_phase(12, 100, 100, 0, 1);

        // Memory back-pressure on requests.
        run_phase(60, 70, 40, 0, 2);

        // Long latency with frequent redirects so squashed responses get dropped.
        run_phase(300, 60, 80, 12, 3);

        // Everything random at once.
        run_phase(400, 50, 60, 6, 3);

        // Fill the buffer, then reset mid-stream and restart from RESET_PC.
        run_phase(10, 0, 100, 0, 1);
        do_reset();
        delivered = 0;
        run_phase(40, 100, 100, 0, 1);
        check("restart_progress", {31'd0, delivered >= 20}, 32'd1);

        run_phase(200, 60, 70, 8, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
